// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte FIFO that sits behind a UART receiver. Each byte arrives
// with a one-cycle newData strobe, is stored in a circular buffer, and is
// presented to the consumer first-word-fall-through: the oldest byte is always
// on data_Out whenever empty_Out is low.
//
// Optional feature (macro UART_RX_FIFO_OVERFLOW_EN):
//   When the macro is defined, a sticky overflow flag is added. It records that
//   a byte was dropped because the FIFO was full. A separate clear input resets
//   it. If the macro is undefined, both ports and their logic are left out, and
//   bytes are still dropped when the FIFO is full.
//
// Parameters
//   DATAWIDTH_BUS  width of one received word (default 8)
//   DEPTH_LOG2     log2 of the FIFO depth (default 4 -> 16 entries)
//
// Ports
//   UART_RX_FIFO_CLOCK_50              in   system clock, rising edge
//   UART_RX_FIFO_RESET_InHigh          in   asynchronous active-high reset
//   UART_RX_FIFO_newData_In            in   one-cycle write strobe
//   UART_RX_FIFO_data_In               in   byte sampled with the strobe
//   UART_RX_FIFO_read_InHigh           in   consumer pop request
//   UART_RX_FIFO_data_Out              out  head (oldest) byte, registered
//   UART_RX_FIFO_empty_Out             out  registered, count == 0
//   UART_RX_FIFO_full_Out              out  registered, count == 2^DEPTH_LOG2
//   UART_RX_FIFO_count_Out             out  registered number of stored bytes
//   UART_RX_FIFO_overflow_Out          out  sticky drop flag (feature only)
//   UART_RX_FIFO_clearOverflow_InHigh  in   clears overflow (feature only)
//
// Handshake
//   Write side: newData_In is a strobe and has no back-pressure. The byte is
//   taken on an edge when the FIFO is not full, or when a pop is accepted on
//   that same edge. Otherwise the byte is dropped.
//   Read side: read_InHigh is a request. It is accepted on an edge only when
//   empty_Out is low. On the following cycle data_Out shows the next byte.
//   A request while empty has no effect. Because of that, a simultaneous write
//   and read on an empty FIFO results only in the write.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int DEPTH_LOG2    = 4
) (
  input  logic                     UART_RX_FIFO_CLOCK_50,
  input  logic                     UART_RX_FIFO_RESET_InHigh,
  input  logic                     UART_RX_FIFO_newData_In,
  input  logic [DATAWIDTH_BUS-1:0] UART_RX_FIFO_data_In,
  input  logic                     UART_RX_FIFO_read_InHigh,
  output logic [DATAWIDTH_BUS-1:0] UART_RX_FIFO_data_Out,
  output logic                     UART_RX_FIFO_empty_Out,
  output logic                     UART_RX_FIFO_full_Out,
`ifdef UART_RX_FIFO_OVERFLOW_EN
  output logic                     UART_RX_FIFO_overflow_Out,
  input  logic                     UART_RX_FIFO_clearOverflow_InHigh,
`endif
  output logic [DEPTH_LOG2:0]      UART_RX_FIFO_count_Out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Short local names for the fixed port names
  logic clk;
  logic rst;
  assign clk = UART_RX_FIFO_CLOCK_50;
  assign rst = UART_RX_FIFO_RESET_InHigh;

  // Storage. The array is not reset; the pointers alone define what is valid.
  logic [DATAWIDTH_BUS-1:0] mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0]    wr_ptr;
  logic [DEPTH_LOG2-1:0]    rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     empty;
  logic                     full;
  logic [DATAWIDTH_BUS-1:0] head;

  // Edge qualifiers. They use only the registered flags, so no path exists from
  // the inputs to the flag outputs within a single cycle.
  logic pop_ok;
  logic write_ok;
  assign pop_ok   = UART_RX_FIFO_read_InHigh && !empty;
  assign write_ok = UART_RX_FIFO_newData_In && (!full || pop_ok);

  // Next-state values
  logic [DEPTH_LOG2-1:0]    wr_ptr_next;
  logic [DEPTH_LOG2-1:0]    rd_ptr_next;
  logic [CNT_W-1:0]         count_next;
  logic [DATAWIDTH_BUS-1:0] head_next;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (write_ok) wr_ptr_next = wr_ptr + PTR_ONE;
    if (pop_ok)   rd_ptr_next = rd_ptr + PTR_ONE;
    if (write_ok && !pop_ok)      count_next = count + CNT_ONE;
    else if (!write_ok && pop_ok) count_next = count - CNT_ONE;
  end

  // Head prefetch for fall-through output. The word at the next read pointer
  // is correct, unless that slot is being written on this same edge. That
  // happens when writing into an empty FIFO, or when writing and popping the
  // last remaining entry together. In both cases the incoming byte becomes the
  // head directly. When the FIFO drains to empty, the value taken is stale,
  // which is acceptable because data_Out is don't-care while empty.
  always_comb begin
    head_next = mem[rd_ptr_next];
    if (write_ok && (wr_ptr == rd_ptr_next)) head_next = UART_RX_FIFO_data_In;
  end

  always_ff @(posedge clk) begin
    if (write_ok) mem[wr_ptr] <= UART_RX_FIFO_data_In;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      empty  <= (count_next == '0);
      full   <= (count_next == CNT_FULL);
      head   <= head_next;
    end
  end

  assign UART_RX_FIFO_data_Out  = head;
  assign UART_RX_FIFO_empty_Out = empty;
  assign UART_RX_FIFO_full_Out  = full;
  assign UART_RX_FIFO_count_Out = count;

`ifdef UART_RX_FIFO_OVERFLOW_EN
  // A byte is lost when a strobe arrives while full and no pop frees a slot.
  // If a drop and a clear happen on the same edge, the drop wins so the event
  // is not lost.
  logic drop;
  logic overflow;
  assign drop = UART_RX_FIFO_newData_In && full && !pop_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    overflow <= 1'b0;
    else if (drop)                              overflow <= 1'b1;
    else if (UART_RX_FIFO_clearOverflow_InHigh) overflow <= 1'b0;
  end

  assign UART_RX_FIFO_overflow_Out = overflow;
`endif

endmodule
